// File: rtl/lcd_refresh_scheduler_pkg.sv
// Shared LCD constants: command encodings, instruction width and 50 MHz timing.
package lcd_refresh_scheduler_pkg;

    localparam int LCD_INSTR_W = 10;
    localparam int LCD_DELAY_W = 26;
    localparam int LCD_CHAR_AW = 5;

    localparam logic [LCD_INSTR_W-1:0] LCD_SET_DDRAM_L1 = 10'h080;
    localparam logic [LCD_INSTR_W-1:0] LCD_SET_DDRAM_L2 = 10'h0C0;
    localparam logic [1:0]             LCD_WRITE_PREFIX = 2'b10;

    // Cycle counts at 50 MHz.
    localparam int LCD_CYC_40US = 2000;
    localparam int LCD_CYC_1S   = 50_000_000;

    localparam logic [LCD_CHAR_AW-1:0] LCD_LINE1_LAST = 5'd15;
    localparam logic [LCD_CHAR_AW-1:0] LCD_FRAME_LAST = 5'd31;

    function automatic logic [LCD_INSTR_W-1:0] lcd_write_cmd(input logic [7:0] ch);
        return {LCD_WRITE_PREFIX, ch};
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Up-counter with synchronous clear; match_o flags the last cycle of an N-cycle delay
// when last_i is loaded with N-1.
module lcd_delay_counter
    import lcd_refresh_scheduler_pkg::*;
#(
    parameter int W = LCD_DELAY_W
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic         match_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign match_o = en_i && (count_q == last_i);

endmodule

// File: rtl/lcd_refresh_scheduler.sv
// Drives the LCD instruction FSM after init: passes init commands through until init_done,
// then streams a 32-char frame (line 1, line 2) from the char ROM followed by a refresh wait.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_WAIT_INIT | init FSM owns the instruction FSM; wait for init_done
// S_ADDR1     | issue set-DDRAM 0x00 (line 1), wait for done
// S_FETCH     | char_addr presented to the ROM, data valid next cycle
// S_WRITE     | issue write of ROM char at idx, wait for done
// S_ADDR2     | issue set-DDRAM 0x40 (line 2), wait for done
// S_GAP       | inter-command gap, then dispatch on idx / previous command
// S_REFRESH   | idle between frames, then restart at line 1
module lcd_refresh_scheduler
    import lcd_refresh_scheduler_pkg::*;
#(
    parameter int INSTR_GAP_CYCLES = LCD_CYC_40US,
    parameter int REFRESH_CYCLES   = LCD_CYC_1S
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   init_done_i,
    input  logic                   init_instr_enable_i,
    input  logic [LCD_INSTR_W-1:0] init_instruction_i,
    input  logic                   instr_fsm_done_i,
    output logic                   instr_fsm_enable_o,
    output logic [LCD_INSTR_W-1:0] instruction_o,
    output logic [LCD_CHAR_AW-1:0] char_addr_o,
    input  logic [7:0]             char_data_i,
    output logic                   frame_done_o
);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_ADDR1,
        S_FETCH,
        S_WRITE,
        S_ADDR2,
        S_GAP,
        S_REFRESH
    } state_t;

    localparam logic [LCD_DELAY_W-1:0] GAP_LAST     = LCD_DELAY_W'(INSTR_GAP_CYCLES - 1);
    localparam logic [LCD_DELAY_W-1:0] REFRESH_LAST = LCD_DELAY_W'(REFRESH_CYCLES - 1);

    state_t                   state_q;
    logic                     en_q;
    logic [LCD_INSTR_W-1:0]   instr_q;
    logic [LCD_CHAR_AW-1:0]   idx_q;
    logic                     frame_done_q;
    logic                     from_write_q;

    logic                     in_delay;
    logic                     dly_match;
    logic [LCD_DELAY_W-1:0]   dly_last;

    assign in_delay = (state_q == S_GAP) || (state_q == S_REFRESH);
    assign dly_last = (state_q == S_REFRESH) ? REFRESH_LAST : GAP_LAST;

    // Held at zero outside the delay states, and re-cleared on a match so that
    // S_GAP -> S_REFRESH starts the refresh count from zero.
    lcd_delay_counter #(.W(LCD_DELAY_W)) u_delay (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (!in_delay || dly_match),
        .en_i    (in_delay),
        .last_i  (dly_last),
        .match_o (dly_match)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_WAIT_INIT;
            en_q         <= 1'b0;
            instr_q      <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            from_write_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (!init_done_i) begin
                state_q <= S_WAIT_INIT;
                en_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_WAIT_INIT: begin
                        state_q <= S_ADDR1;
                        en_q    <= 1'b1;
                        instr_q <= LCD_SET_DDRAM_L1;
                        idx_q   <= '0;
                    end
                    S_ADDR1, S_ADDR2: begin
                        if (instr_fsm_done_i) begin
                            state_q      <= S_GAP;
                            en_q         <= 1'b0;
                            from_write_q <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        state_q <= S_WRITE;
                        en_q    <= 1'b1;
                    end
                    S_WRITE: begin
                        if (instr_fsm_done_i) begin
                            state_q      <= S_GAP;
                            en_q         <= 1'b0;
                            from_write_q <= 1'b1;
                            frame_done_q <= (idx_q == LCD_FRAME_LAST);
                        end
                    end
                    S_GAP: begin
                        if (dly_match) begin
                            if (!from_write_q) begin
                                state_q <= S_FETCH;
                            end else if (idx_q == LCD_LINE1_LAST) begin
                                idx_q   <= idx_q + 5'd1;
                                state_q <= S_ADDR2;
                                en_q    <= 1'b1;
                                instr_q <= LCD_SET_DDRAM_L2;
                            end else if (idx_q == LCD_FRAME_LAST) begin
                                state_q <= S_REFRESH;
                            end else begin
                                idx_q   <= idx_q + 5'd1;
                                state_q <= S_FETCH;
                            end
                        end
                    end
                    S_REFRESH: begin
                        if (dly_match) begin
                            idx_q   <= '0;
                            state_q <= S_ADDR1;
                            en_q    <= 1'b1;
                            instr_q <= LCD_SET_DDRAM_L1;
                        end
                    end
                    default: begin
                        state_q <= S_WAIT_INIT;
                        en_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // In S_WRITE the command comes straight from the synchronous ROM register, which is
    // stable for the whole command because char_addr does not move until S_GAP ends.
    assign instr_fsm_enable_o = init_done_i ? en_q : init_instr_enable_i;
    assign instruction_o      = !init_done_i          ? init_instruction_i :
                                (state_q == S_WRITE)  ? lcd_write_cmd(char_data_i) :
                                                        instr_q;
    assign char_addr_o        = idx_q;
    assign frame_done_o       = frame_done_q;

endmodule
